// File: rtl/sram_64x64x8.sv
// 4 KiB single-port synchronous RAM, 64 rows x 64 cols x 8 bits. Optional macro: SRAM_MEM_CLEAR_EN.
// Latency: write commits at the sampling edge; read data is registered, valid 1 cycle after the read edge.
// Backpressure: none; every edge with CS low completes one transfer, data_out holds between reads.
module sram_64x64x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       CS,
  input  logic       RW,
  input  logic [5:0] Address_Row,
  input  logic [5:0] Address_Col,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned DEPTH = 4096;

  // Row-major flattening of mem[row][col]; every 12-bit index is a real location.
  logic [7:0]  mem [0:DEPTH-1];
  logic [11:0] addr;
  logic        wr_en;
  logic        rd_en;

  assign addr  = {Address_Row, Address_Col};
  assign wr_en = !rst && !CS && !RW;
  assign rd_en = !rst && !CS &&  RW;

`ifdef SRAM_MEM_CLEAR_EN
  // Whole-array clear in the reset cycle forces a register-based array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[addr] <= data_in;
    end
  end
`else
  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (rd_en) begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sram_64x64x8.sv
// Scoreboard bench for sram_64x64x8; expectations follow SRAM_MEM_CLEAR_EN when defined.
module tb_sram_64x64x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       CS;
  logic       RW;
  logic [5:0] Address_Row;
  logic [5:0] Address_Col;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [0:4095];
  logic [7:0] exp_dout;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sram_64x64x8 dut (
    .clk         (clk),
    .rst         (rst),
    .CS          (CS),
    .RW          (RW),
    .Address_Row (Address_Row),
    .Address_Col (Address_Col),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict data_out after the edge, then compare against the queue head.
  task automatic cyc(input string tag, input logic r, input logic cs, input logic rw,
                     input logic [5:0] row, input logic [5:0] col, input logic [7:0] din);
    logic [7:0] e;
    @(negedge clk);
    rst = r; CS = cs; RW = rw;
    Address_Row = row; Address_Col = col; data_in = din;
    if (r) begin
      exp_dout = 8'h00;
`ifdef SRAM_MEM_CLEAR_EN
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
`endif
    end else if (!cs) begin
      if (!rw) ref_mem[{row, col}] = din;
      else     exp_dout = ref_mem[{row, col}];
    end
    exp_q.push_back(exp_dout);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, data_out, e);
  endtask

  initial begin
    logic [7:0] rst_val;
    rst = 1'b1; CS = 1'b1; RW = 1'b1;
    Address_Row = '0; Address_Col = '0; data_in = '0;
    exp_dout = 8'h00;

    // Reset with a write-shaped cycle presented; it must not land.
    cyc("rst0", 1'b1, 1'b0, 1'b0, 6'd1, 6'd2, 8'hFF);
    cyc("rst1", 1'b1, 1'b0, 1'b0, 6'd1, 6'd2, 8'hFF);

    // Known value at (3,3), then reset while addressing it with FF on data_in.
    cyc("wr33",     1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 8'h11);
    cyc("rst_wr_a", 1'b1, 1'b0, 1'b0, 6'd3, 6'd3, 8'hFF);
    cyc("rst_wr_b", 1'b1, 1'b0, 1'b0, 6'd3, 6'd3, 8'hFF);
`ifdef SRAM_MEM_CLEAR_EN
    rst_val = 8'h00;
`else
    rst_val = 8'h11;
`endif
    cyc("rd33_after_rst", 1'b0, 1'b0, 1'b1, 6'd3, 6'd3, 8'h00);
    chk("rd33_value", data_out, rst_val);

    // Write then read back, data_in ignored on reads.
    cyc("wr12",     1'b0, 1'b0, 1'b0, 6'd1, 6'd2, 8'h80);
    cyc("rd12",     1'b0, 1'b0, 1'b1, 6'd1, 6'd2, 8'h40);
    cyc("rd12_again", 1'b0, 1'b0, 1'b1, 6'd1, 6'd2, 8'h40);

    // data_out holds across a write.
    cyc("wr21_hold", 1'b0, 1'b0, 1'b0, 6'd2, 6'd1, 8'h80);
    cyc("rd21",      1'b0, 1'b0, 1'b1, 6'd2, 6'd1, 8'h00);
    cyc("rd12_b",    1'b0, 1'b0, 1'b1, 6'd1, 6'd2, 8'h00);

    // Deselected write is ignored and data_out holds.
    cyc("wr33_c",    1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 8'h22);
    cyc("rd33_c",    1'b0, 1'b0, 1'b1, 6'd3, 6'd3, 8'h00);
    cyc("idle_hold", 1'b0, 1'b1, 1'b0, 6'd1, 6'd2, 8'h55);
    cyc("rd12_desel", 1'b0, 1'b0, 1'b1, 6'd1, 6'd2, 8'h00);
    chk("rd12_desel_val", data_out, 8'h80);

    // Corners and aliasing.
    cyc("wr_0_0",   1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  8'hA5);
    cyc("wr_63_63", 1'b0, 1'b0, 1'b0, 6'd63, 6'd63, 8'h5A);
    cyc("wr_63_0",  1'b0, 1'b0, 1'b0, 6'd63, 6'd0,  8'h3C);
    cyc("rd_0_0",   1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  8'h00);
    chk("rd_0_0_val", data_out, 8'hA5);
    cyc("rd_63_63", 1'b0, 1'b0, 1'b1, 6'd63, 6'd63, 8'h00);
    chk("rd_63_63_val", data_out, 8'h5A);
    cyc("rd_63_0",  1'b0, 1'b0, 1'b1, 6'd63, 6'd0,  8'h00);
    chk("rd_63_0_val", data_out, 8'h3C);
    cyc("rd_0_63",  1'b0, 1'b0, 1'b1, 6'd0,  6'd63, 8'h00);

    // Reset pulse vs. memory contents.
    cyc("wr55",     1'b0, 1'b0, 1'b0, 6'd5, 6'd5, 8'h77);
    cyc("rst_pulse", 1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 8'h00);
    cyc("rd55",     1'b0, 1'b0, 1'b1, 6'd5, 6'd5, 8'h00);
`ifdef SRAM_MEM_CLEAR_EN
    chk("rd55_val", data_out, 8'h00);
`else
    chk("rd55_val", data_out, 8'h77);
`endif

    // Random traffic over a small window so reads often hit written bytes.
    for (int n = 0; n < 400; n++) begin
      cyc("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
          $urandom_range(0, 1),
          6'($urandom_range(0, 3) * 21), 6'($urandom_range(0, 3) * 21),
          8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
